// File: rtl/wac_multi_dac_ctrl.sv
`default_nettype none
// wac_multi_dac_ctrl: serial frame engine for a DAC plus digital pots sharing sclk/sdi,
// one active-low chip select per target, optional broadcast to all targets at once.
module wac_multi_dac_ctrl #(
  parameter int N_CH    = 3,
  parameter int WORD_W  = 16,
  parameter int CLK_DIV = 2,
  localparam int CHW    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrlEn,
  input  logic [CHW-1:0]    chSel,
  input  logic              bcast,
  input  logic [WORD_W-1:0] confWord,
  output logic              sclk,
  output logic              sdi,
  output logic [N_CH-1:0]   csN,
  output logic              busy,
  output logic              done,
  output logic              errStb
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(WORD_W + 1);
  localparam logic [DW-1:0]  c_DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0]  c_LAST_BIT = BW'(WORD_W - 1);
  localparam logic [BW-1:0]  c_WORD     = BW'(WORD_W);
  localparam logic [CHW:0]   c_NCH      = (CHW + 1)'(N_CH);

  state_t              state_q, state_d;
  logic [DW-1:0]       div_q, div_d;
  logic [BW-1:0]       bit_q, bit_d;
  logic [WORD_W-1:0]   sh_q, sh_d;
  logic [N_CH-1:0]     sel_q, sel_d;
  logic                sclk_q, sclk_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                div_end;
  logic                req_valid;
  logic [N_CH-1:0]     req_mask;
  logic                frame_act;

  assign div_end   = (div_q == c_DIV_LAST);
  assign req_valid = bcast || ({1'b0, chSel} < c_NCH);
  assign req_mask  = bcast ? {N_CH{1'b1}} : (N_CH'(1) << chSel);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    sel_d   = sel_q;
    sclk_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        div_d = '0;
        bit_d = '0;
        if (ctrlEn) begin
          if (req_valid) begin
            sh_d    = confWord;
            sel_d   = req_mask;
            state_d = S_SETUP;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_SETUP: begin
        err_d = ctrlEn;
        if (div_end) begin
          div_d   = '0;
          state_d = S_SHIFT;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_SHIFT: begin
        err_d  = ctrlEn;
        sclk_d = sclk_q;
        if (div_end) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          // Data advances only on the falling edge so it is stable at each rise.
          if (sclk_q) begin
            sh_d = sh_q << 1;
            if (bit_q == c_LAST_BIT) begin
              bit_d   = c_WORD;
              state_d = S_HOLD;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_HOLD: begin
        err_d = ctrlEn;
        if (div_end) begin
          div_d   = '0;
          state_d = S_GAP;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_GAP: begin
        err_d = ctrlEn;
        if (div_end) begin
          div_d   = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      sel_q   <= '0;
      sclk_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      sel_q   <= sel_d;
      sclk_q  <= sclk_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign frame_act = (state_q == S_SETUP) || (state_q == S_SHIFT) || (state_q == S_HOLD);
  assign csN       = frame_act ? ~sel_q : {N_CH{1'b1}};
  assign sdi       = frame_act ? sh_q[WORD_W-1] : 1'b0;
  assign sclk      = sclk_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign errStb    = err_q;

endmodule
`default_nettype wire
